// File: rtl/seed_reporter_pkg.sv
// Shared definitions for the seed reporter: FSM encoding, report framing
// constants and the nibble-to-ASCII helper.
package seed_reporter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        HOLD = 2'd3
    } state_e;

    // 'S', eight hex digits, CR, LF
    localparam int         REPORT_LEN = 11;
    localparam logic [3:0] LAST_INDEX = 4'(REPORT_LEN - 1);

    localparam logic [7:0] ASCII_S  = 8'h53;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Uppercase hex digit: 0-9 -> '0'..'9', 10-15 -> 'A'..'F'
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'd0, nib};
        end else begin
            return 8'h37 + {4'd0, nib};
        end
    endfunction

endpackage

// File: rtl/seed_reporter_uart_tx.sv
// 8N1 serial transmitter. A frame is ten bit slots (start, 8 data LSB first,
// stop), each CLKS_PER_BIT cycles long. CLKS_PER_BIT must be at least 2.
// 'finished' pulses in the second-to-last cycle of the stop bit so the
// controller can present the next byte during the final stop cycle; a start
// accepted in that final cycle chains the next frame with no idle gap.
module uart_tx #(
    parameter int CLKS_PER_BIT = 138
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic [7:0] data,
    output logic       TX,
    output logic       active,
    output logic       finished
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BAUD_PRE  = CW'(CLKS_PER_BIT - 2);
    localparam logic [3:0]    STOP_SLOT = 4'd9;
    localparam logic [3:0]    LAST_DATA = 4'd8;

    logic          tx_q, tx_d;
    logic          active_q, active_d;
    logic [3:0]    slot_q, slot_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [7:0]    shift_q, shift_d;

    logic bit_end;
    logic frame_end;
    logic accept;

    assign bit_end   = (baud_q == BAUD_LAST);
    assign frame_end = active_q && bit_end && (slot_q == STOP_SLOT);
    assign accept    = start && (!active_q || frame_end);

    assign TX       = tx_q;
    assign active   = active_q;
    assign finished = active_q && (slot_q == STOP_SLOT) && (baud_q == BAUD_PRE);

    // Next-state for the bit/baud counters and the serial line
    always_comb begin
        tx_d     = tx_q;
        active_d = active_q;
        slot_d   = slot_q;
        baud_d   = baud_q;
        shift_d  = shift_q;
        if (accept) begin
            active_d = 1'b1;
            slot_d   = 4'd0;
            baud_d   = '0;
            shift_d  = data;
            tx_d     = 1'b0;
        end else if (active_q) begin
            if (bit_end) begin
                baud_d = '0;
                if (slot_q == STOP_SLOT) begin
                    // line is already high from the stop bit
                    active_d = 1'b0;
                    slot_d   = 4'd0;
                end else begin
                    slot_d = slot_q + 4'd1;
                    if (slot_q == LAST_DATA) begin
                        tx_d = 1'b1;
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end else begin
                baud_d = baud_q + CW'(1);
            end
        end
    end

    // Transmitter state register; reset forces the line idle immediately
    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_q     <= 1'b1;
            active_q <= 1'b0;
            slot_q   <= 4'd0;
            baud_q   <= '0;
            shift_q  <= 8'd0;
        end else begin
            tx_q     <= tx_d;
            active_q <= active_d;
            slot_q   <= slot_d;
            baud_q   <= baud_d;
            shift_q  <= shift_d;
        end
    end

endmodule

// File: rtl/seed_reporter.sv
// Seed reporter: when the guess stage raises 'done', capture the seed and send
// "S" + 8 hex digits + CR LF over UART. A new report needs 'done' to be seen
// low first, so a level held high reports exactly once.
module seed_reporter #(
    parameter int CLK_HZ = 16000000,
    parameter int BAUD   = 115200
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        done,
    input  logic [31:0] valid_seed,
    output logic        TX,
    output logic        busy,
    output logic        sent
);

    import seed_reporter_pkg::*;

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

    state_e      state_q, state_d;
    logic [3:0]  index_q, index_d;
    logic        armed_q, armed_d;
    logic [31:0] seed_q, seed_d;

    logic        tx_start;
    logic [7:0]  tx_byte;
    logic        tx_active;
    logic        tx_finished;
    logic [31:0] seed_shifted;

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .CLK     (CLK),
        .RST     (RST),
        .start   (tx_start),
        .data    (tx_byte),
        .TX      (TX),
        .active  (tx_active),
        .finished(tx_finished)
    );

    // Digit k (index 1..8) is the nibble at bits [4*(8-k)+3 : 4*(8-k)]
    assign seed_shifted = seed_q >> {(4'd8 - index_q), 2'b00};

    // Select the report byte for the current index
    always_comb begin
        tx_byte = ASCII_S;
        case (index_q)
            4'd0:    tx_byte = ASCII_S;
            4'd9:    tx_byte = ASCII_CR;
            4'd10:   tx_byte = ASCII_LF;
            default: tx_byte = hex_ascii(seed_shifted[3:0]);
        endcase
    end

    // Report sequencing: capture, strobe each byte, wait, signal completion
    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        armed_d  = armed_q;
        seed_d   = seed_q;
        tx_start = 1'b0;
        sent     = 1'b0;
        busy     = (state_q != IDLE);

        // any sampled low re-arms, regardless of state
        if (!done) begin
            armed_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (done && armed_q) begin
                    seed_d  = valid_seed;
                    armed_d = 1'b0;
                    index_d = 4'd0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                tx_start = 1'b1;
                state_d  = SEND;
            end
            SEND: begin
                if (tx_finished) begin
                    if (index_q < LAST_INDEX) begin
                        index_d = index_q + 4'd1;
                        state_d = LOAD;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // entered during the final stop cycle; complete once the line is released
                if (!tx_active) begin
                    sent    = 1'b1;
                    busy    = 1'b0;
                    index_d = 4'd0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            index_q <= 4'd0;
            armed_q <= 1'b1;
            seed_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            armed_q <= armed_d;
            seed_q  <= seed_d;
        end
    end

endmodule

// File: tb/tb_seed_reporter.sv
// Bench for seed_reporter at CLKS_PER_BIT = 4. Stimulus pushes the expected
// report bytes into a queue; a UART monitor decodes TX and pops/compares,
// and a busy monitor checks report duration and the sent pulse.
module tb_seed_reporter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        done = 1'b0;
    logic [31:0] valid_seed = 32'd0;
    logic        TX;
    logic        busy;
    logic        sent;

    seed_reporter #(
        .CLK_HZ(16),
        .BAUD  (4)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .done      (done),
        .valid_seed(valid_seed),
        .TX        (TX),
        .busy      (busy),
        .sent      (sent)
    );

    always #5 CLK = ~CLK;

    localparam int BIT_CYC     = 4;
    localparam int BUSY_CYCLES = 1 + 11 * 10 * BIT_CYC;

    // Hand-written reports: seed 96, seed 0xDEADBEEF, seed 0xA5
    localparam logic [7:0] EXP [33] = '{
        8'h53, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h36, 8'h30, 8'h0D, 8'h0A,
        8'h53, 8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A,
        8'h53, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h41, 8'h35, 8'h0D, 8'h0A
    };

    int         n_checks = 0;
    int         n_pass   = 0;
    int         sent_cnt = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push_report(input int r);
        for (int i = 0; i < 11; i++) exp_q.push_back(EXP[r * 11 + i]);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_sent(input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge CLK);
            if (sent) seen = 1'b1;
        end
        check("sent_seen", 32'(seen), 32'd1);
    endtask

    // UART frame decoder and scoreboard consumer
    initial begin : uart_mon
        logic       prev;
        logic       just_ended;
        logic       stable;
        logic       aborted;
        logic [9:0] bits;
        logic [7:0] e;
        prev       = 1'b1;
        just_ended = 1'b0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                prev       = 1'b1;
                just_ended = 1'b0;
            end else begin
                if (just_ended && busy) check("no_gap_start", 32'(TX), 32'd0);
                just_ended = 1'b0;
                if (prev && !TX) begin
                    stable  = 1'b1;
                    aborted = 1'b0;
                    bits    = '0;
                    for (int k = 0; k < 10 * BIT_CYC && !aborted; k++) begin
                        if (k > 0) @(negedge CLK);
                        if (RST) begin
                            aborted = 1'b1;
                        end else if (k % BIT_CYC == 0) begin
                            bits[k / BIT_CYC] = TX;
                        end else if (TX !== bits[k / BIT_CYC]) begin
                            stable = 1'b0;
                        end
                    end
                    if (!aborted) begin
                        check("framing", {29'd0, stable, bits[0], bits[9]}, 32'b101);
                        check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            check("byte", {24'd0, bits[8:1]}, {24'd0, e});
                        end
                        just_ended = 1'b1;
                    end
                    prev = 1'b1;
                end else begin
                    prev = TX;
                end
            end
        end
    end

    // Busy duration and sent alignment
    initial begin : busy_mon
        int   cnt;
        logic prevb;
        cnt   = 0;
        prevb = 1'b0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                cnt   = 0;
                prevb = 1'b0;
            end else begin
                if (sent) sent_cnt++;
                if (prevb && !busy) begin
                    check("busy_len", 32'(cnt), 32'(BUSY_CYCLES));
                    check("sent_at_busy_fall", 32'(sent), 32'd1);
                end
                if (busy) cnt++;
                else cnt = 0;
                prevb = busy;
            end
        end
    end

    initial begin : watchdog
        repeat (50000) @(posedge CLK);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int no_trig;
        RST  = 1'b1;
        done = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_tx", 32'(TX), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_sent", 32'(sent), 32'd0);
        step(1);
        RST = 1'b0;

        // seed 96, then corrupt valid_seed during byte 2
        step(2);
        push_report(0);
        valid_seed = 32'd96;
        done       = 1'b1;
        step(100);
        valid_seed = 32'h12345678;
        wait_sent(600);

        // done held high: no new report
        no_trig = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge CLK);
            if (!TX || busy) no_trig++;
        end
        check("held_done_no_retrigger", 32'(no_trig), 32'd0);

        // re-arm with a one-cycle low, seed 0xDEADBEEF
        step(1);
        done       = 1'b0;
        valid_seed = 32'hDEADBEEF;
        push_report(1);
        step(1);
        done = 1'b1;
        wait_sent(600);

        // seed 0xA5, reset in the middle of byte 4
        step(1);
        done       = 1'b0;
        valid_seed = 32'h000000A5;
        push_report(2);
        step(1);
        done = 1'b1;
        step(180);
        check("pending_before_reset", 32'(exp_q.size()), 32'd7);
        RST = 1'b1;
        step(1);
        RST = 1'b0;
        exp_q.delete();
        push_report(2);
        @(negedge CLK);
        check("mid_reset_tx", 32'(TX), 32'd1);
        check("mid_reset_busy", 32'(busy), 32'd0);
        wait_sent(600);

        step(5);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("sent_pulses", 32'(sent_cnt), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
